// File: rtl/noc_sink_client.sv
`default_nettype none
// ============================================================================
// noc_sink_client : BFT NoC receive endpoint, checks dest/ordering, counts pkts
// Revision: 1.0
// ============================================================================
module noc_sink_client #(
    parameter int N     = 2,
    parameter int D_W   = 32,
    parameter int A_W   = $clog2(N) + 1,
    parameter int posx  = 0,
    parameter int LIMIT = 1024,
    parameter int RATE  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [A_W+D_W:0] s_axis_c_wdata,
    input  logic             s_axis_c_wvalid,
    output logic             s_axis_c_wready,
    input  logic             s_axis_c_wlast,
    output logic [31:0]      rx_pkts,
    output logic [15:0]      err_cnt,
    output logic             done
);

    localparam int SI_W = (N > 1) ? $clog2(N) : 1;
    localparam int S_W  = D_W - 16;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BODY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [A_W-1:0] c_POSX  = A_W'(posx);
    localparam logic [S_W-1:0] c_NSRC  = S_W'(N);
    localparam logic [31:0]    c_LIMIT = 32'(LIMIT);

    logic [1:0]     state_q, state_d;
    logic           wready_q, wready_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [31:0]    rx_q, rx_d;
    logic [15:0]    err_q, err_d;
    logic           done_q, done_d;
    logic [A_W-1:0] hdr_dest_q, hdr_dest_d;
    logic [15:0]    exp_seq_q [N];

    logic [A_W-1:0]  w_dest;
    logic [S_W-1:0]  w_src;
    logic [15:0]     w_seq;
    logic [SI_W-1:0] w_src_idx;
    logic            w_accept, w_hdr, w_body;
    logic            w_src_ok, w_dest_ok, w_hdr_valid, w_err;
    logic            w_rate_ok, w_fb;
    logic            w_unused_rsvd;

    assign w_dest        = s_axis_c_wdata[A_W+D_W:D_W+1];
    assign w_src         = s_axis_c_wdata[D_W-1:16];
    assign w_seq         = s_axis_c_wdata[15:0];
    assign w_src_idx     = w_src[SI_W-1:0];
    assign w_unused_rsvd = s_axis_c_wdata[D_W];

    assign w_accept = s_axis_c_wvalid & wready_q & ce;
    // Once the packet budget is reached, IDLE goes to DONE instead of accepting.
    assign w_hdr  = w_accept && (state_q == c_IDLE) && (rx_q != c_LIMIT);
    assign w_body = w_accept && (state_q == c_BODY);

    assign w_src_ok    = (w_src < c_NSRC);
    assign w_dest_ok   = (w_dest == c_POSX);
    assign w_hdr_valid = w_hdr & w_src_ok & w_dest_ok;
    assign w_err       = (w_hdr & ~(w_src_ok & w_dest_ok))
                       | (w_hdr_valid & (w_seq != exp_seq_q[w_src_idx]))
                       | (w_body & (w_dest != hdr_dest_q));

    assign w_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    generate
        if (RATE >= 100) begin : g_no_bp
            assign w_rate_ok = 1'b1;
        end else begin : g_bp
            localparam logic [6:0] c_RATE = 7'(RATE);
            assign w_rate_ok = ((lfsr_q[6:0] % 7'd100) < c_RATE);
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        rx_d       = rx_q;
        err_d      = err_q;
        done_d     = done_q;
        hdr_dest_d = hdr_dest_q;
        if (ce) begin
            lfsr_d = {lfsr_q[14:0], w_fb};
            case (state_q)
                c_IDLE: begin
                    if (rx_q == c_LIMIT) begin
                        state_d = c_DONE;
                    end else if (w_hdr) begin
                        if (s_axis_c_wlast) begin
                            rx_d = rx_q + 32'd1;
                        end else begin
                            state_d    = c_BODY;
                            hdr_dest_d = w_dest;
                        end
                    end
                end
                c_BODY: begin
                    if (w_body && s_axis_c_wlast) begin
                        state_d = c_IDLE;
                        rx_d    = rx_q + 32'd1;
                    end
                end
                c_DONE:  done_d  = 1'b1;
                default: state_d = c_IDLE;
            endcase
            if (w_err && (err_q != 16'hFFFF)) begin
                err_d = err_q + 16'd1;
            end
        end
        // Ready looks ahead so the flit after the LIMIT-th packet is never offered a slot.
        wready_d = ce && (state_d != c_DONE)
                      && !((state_d == c_IDLE) && (rx_d == c_LIMIT))
                      && w_rate_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            wready_q   <= 1'b0;
            lfsr_q     <= 16'hACE1;
            rx_q       <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            hdr_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            wready_q   <= wready_d;
            lfsr_q     <= lfsr_d;
            rx_q       <= rx_d;
            err_q      <= err_d;
            done_q     <= done_d;
            hdr_dest_q <= hdr_dest_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                exp_seq_q[i] <= '0;
            end
        end else if (w_hdr_valid) begin
            exp_seq_q[w_src_idx] <= w_seq + 16'd1;
        end
    end

    assign s_axis_c_wready = wready_q;
    assign rx_pkts         = rx_q;
    assign err_cnt         = err_q;
    assign done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_sink_client.sv
`default_nettype none
// ============================================================================
// tb_noc_sink_client : directed bench for noc_sink_client (three configurations)
// Revision: 1.0
// ============================================================================
module tb_noc_sink_client;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance: posx=3, no backpressure
    logic        m_ce, m_wvalid, m_wlast, m_wready, m_done;
    logic [35:0] m_wdata;
    logic [31:0] m_rx;
    logic [15:0] m_err;

    // Done instance: LIMIT=4
    logic        d_ce, d_wvalid, d_wlast, d_wready, d_done;
    logic [35:0] d_wdata;
    logic [31:0] d_rx;
    logic [15:0] d_err;

    // Backpressure instance: RATE=25
    logic        b_ce, b_wvalid, b_wlast, b_wready, b_done;
    logic [35:0] b_wdata;
    logic [31:0] b_rx;
    logic [15:0] b_err;

    noc_sink_client #(.N(4), .D_W(32), .posx(3), .LIMIT(1024), .RATE(100)) u_main (
        .clk(clk), .rst(rst), .ce(m_ce),
        .s_axis_c_wdata(m_wdata), .s_axis_c_wvalid(m_wvalid),
        .s_axis_c_wready(m_wready), .s_axis_c_wlast(m_wlast),
        .rx_pkts(m_rx), .err_cnt(m_err), .done(m_done)
    );

    noc_sink_client #(.N(4), .D_W(32), .posx(3), .LIMIT(4), .RATE(100)) u_done (
        .clk(clk), .rst(rst), .ce(d_ce),
        .s_axis_c_wdata(d_wdata), .s_axis_c_wvalid(d_wvalid),
        .s_axis_c_wready(d_wready), .s_axis_c_wlast(d_wlast),
        .rx_pkts(d_rx), .err_cnt(d_err), .done(d_done)
    );

    noc_sink_client #(.N(4), .D_W(32), .posx(3), .LIMIT(20000), .RATE(25)) u_bp (
        .clk(clk), .rst(rst), .ce(b_ce),
        .s_axis_c_wdata(b_wdata), .s_axis_c_wvalid(b_wvalid),
        .s_axis_c_wready(b_wready), .s_axis_c_wlast(b_wlast),
        .rx_pkts(b_rx), .err_cnt(b_err), .done(b_done)
    );

    typedef struct {
        logic [2:0] dest;
        int         src;
        int         seq;
        logic       last;
        int         exp_rx;
        int         exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [35:0] mkflit(input logic [2:0] d, input int s, input int q);
        logic [15:0] s16, q16;
        s16 = s[15:0];
        q16 = q[15:0];
        return {d, 1'b0, s16, q16};
    endfunction

    function automatic vec_t mk(input logic [2:0] d, input int s, input int q,
                                input logic l, input int rx, input int er);
        vec_t v;
        v.dest = d; v.src = s; v.seq = q; v.last = l; v.exp_rx = rx; v.exp_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic m_send(input logic [2:0] d, input int s, input int q, input logic last);
        int guard;
        guard    = 0;
        m_wdata  = mkflit(d, s, q);
        m_wlast  = last;
        m_wvalid = 1'b1;
        while (!(m_wready && m_ce) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("m_send timeout", guard, 0);
        @(negedge clk);
        m_wvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, ready_seen, acc, bad, r;
        logic [31:0] prev;

        // Packet table: 10 four-flit packets from src 1, then error cases
        for (int p = 0; p < 10; p++) begin
            for (int f = 0; f < 4; f++) begin
                vecs.push_back(mk(3'd3, (f == 0) ? 1 : 5, (f == 0) ? p : 99,
                                  (f == 3), (f == 3) ? p + 1 : p, 0));
            end
        end
        vecs.push_back(mk(3'd2, 2, 0, 1'b1, 11, 1));   // wrong dest
        vecs.push_back(mk(3'd3, 0, 0, 1'b1, 12, 1));
        vecs.push_back(mk(3'd3, 0, 1, 1'b1, 13, 1));
        vecs.push_back(mk(3'd3, 0, 2, 1'b1, 14, 1));
        vecs.push_back(mk(3'd3, 0, 5, 1'b1, 15, 2));   // seq gap, resync to 6
        vecs.push_back(mk(3'd3, 0, 6, 1'b1, 16, 2));
        vecs.push_back(mk(3'd3, 7, 0, 1'b1, 17, 3));   // src out of range
        vecs.push_back(mk(3'd3, 0, 7, 1'b0, 17, 3));
        vecs.push_back(mk(3'd5, 0, 0, 1'b1, 18, 4));   // body dest mismatch
        vecs.push_back(mk(3'd1, 9, 0, 1'b1, 19, 5));   // two faults, one count

        m_ce = 1'b1; d_ce = 1'b1; b_ce = 1'b1;
        d_wvalid = 1'b0; d_wlast = 1'b0; d_wdata = '0;
        b_wvalid = 1'b0; b_wlast = 1'b0; b_wdata = '0;

        // Reset with valid asserted
        rst = 1'b1;
        m_wvalid = 1'b1; m_wlast = 1'b1; m_wdata = mkflit(3'd3, 1, 0);
        repeat (2) begin
            @(negedge clk);
            chk("reset wready", m_wready, 0);
            chk("reset rx_pkts", m_rx, 0);
            chk("reset err_cnt", m_err, 0);
            chk("reset done", m_done, 0);
        end
        rst = 1'b0;
        m_wvalid = 1'b0;
        @(negedge clk);
        chk("wready after reset", m_wready, 1);

        // Table-driven in-order and error traffic
        foreach (vecs[i]) begin
            m_send(vecs[i].dest, vecs[i].src, vecs[i].seq, vecs[i].last);
            chk($sformatf("vec%0d rx_pkts", i), m_rx, vecs[i].exp_rx);
            chk($sformatf("vec%0d err_cnt", i), m_err, vecs[i].exp_err);
        end
        chk("main done stays low", m_done, 0);

        // ce=0 after two flits of a four-flit packet
        m_send(3'd3, 1, 10, 1'b0);
        m_send(3'd3, 5, 0, 1'b0);
        m_ce = 1'b0;
        m_wdata = mkflit(3'd6, 1, 0); m_wlast = 1'b1; m_wvalid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("ce0 wready", m_wready, 0);
            chk("ce0 rx_pkts", m_rx, 19);
            chk("ce0 err_cnt", m_err, 5);
        end
        m_wvalid = 1'b0;
        m_ce = 1'b1;
        @(negedge clk);
        m_send(3'd3, 5, 0, 1'b0);
        chk("third flit rx_pkts", m_rx, 19);
        chk("third flit err_cnt", m_err, 5);

        // rst mid-packet after the third flit
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midpkt rst rx_pkts", m_rx, 0);
        chk("midpkt rst err_cnt", m_err, 0);
        chk("midpkt rst wready", m_wready, 0);
        chk("midpkt rst done", m_done, 0);
        @(negedge clk);
        m_send(3'd3, 0, 0, 1'b1);       // src 0 expected seq back at 0
        chk("post rst rx 1", m_rx, 1);
        chk("post rst err 1", m_err, 0);
        m_send(3'd3, 1, 5, 1'b1);       // src 1 expects 0
        chk("post rst rx 2", m_rx, 2);
        chk("post rst err 2", m_err, 1);
        m_send(3'd3, 1, 6, 1'b1);
        chk("post rst rx 3", m_rx, 3);
        chk("post rst err 3", m_err, 1);

        // LIMIT=4: four packets accepted, the fifth never is
        for (int k = 0; k < 4; k++) begin
            d_wdata = mkflit(3'd3, 0, k); d_wlast = 1'b1; d_wvalid = 1'b1;
            guard = 0;
            while (!d_wready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("done send timeout", guard, 0);
            @(negedge clk);
            d_wvalid = 1'b0;
            chk($sformatf("limit pkt%0d rx_pkts", k), d_rx, k + 1);
        end
        chk("done low right after 4th", d_done, 0);
        d_wdata = mkflit(3'd3, 0, 4); d_wvalid = 1'b1;
        ready_seen = 0;
        repeat (20) begin
            if (d_wready) ready_seen++;
            @(negedge clk);
        end
        d_wvalid = 1'b0;
        chk("fifth pkt ready seen", ready_seen, 0);
        chk("limit rx_pkts", d_rx, 4);
        chk("limit done", d_done, 1);
        chk("limit err_cnt", d_err, 0);

        // RATE=25: every accept must coincide with wready. The 7-bit LFSR slice
        // mod 100 folds 100..127 onto 0..27, so 50 of 128 values pass (~39%).
        b_wdata = mkflit(3'd3, 7, 0); b_wlast = 1'b1; b_wvalid = 1'b1;
        acc = 0; bad = 0;
        for (int i = 0; i < 10000; i++) begin
            r = b_wready ? 1 : 0;
            prev = b_rx;
            @(negedge clk);
            if (b_rx != prev + 32'(r)) bad++;
            acc += r;
        end
        b_wvalid = 1'b0;
        chk("bp accept only with wready", bad, 0);
        chk("bp accept ratio in window", (acc >= 3300 && acc <= 4500) ? 1 : 0, 1);
        chk("bp rx_pkts equals ready cycles", b_rx, acc);
        chk("bp done low", b_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
